// File: rtl/fdiv_meter.sv
// Divided-clock meter: measures the period and high time of an asynchronous square wave
// in CLK cycles, and flags divide-ratio match, ~50% duty and missing edges.
module fdiv_meter #(
   parameter int CW       = 8,
   parameter int EXP_DIV  = 5,
   parameter int TO_LIMIT = 255
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          EN,
   input  logic          SIG_IN,
   output logic [CW-1:0] PERIOD,
   output logic [CW-1:0] HIGH_T,
   output logic          VALID,
   output logic          DIV_OK,
   output logic          DUTY_OK,
   output logic          TIMEOUT
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

   localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] EXP_DIV_C = CW'(EXP_DIV);
   localparam logic [CW-1:0] TO_LIM_C  = CW'(TO_LIMIT);
   localparam logic [CW:0]   ONE_EXT_C = {{CW{1'b0}}, 1'b1};

   state_t        r_state;
   logic          r_s1, r_s2, r_s3;
   logic [CW-1:0] r_cnt, r_hcnt;
   logic          r_low_seen;
   logic [CW-1:0] r_period, r_high_t;
   logic          r_valid, r_div_ok, r_duty_ok, r_timeout;

   logic          w_rise, w_high, w_at_limit;
   logic          w_div_ok, w_duty_ok;
   logic [CW:0]   w_twice_h, w_per_ext, w_diff;

   assign w_rise     = r_s2 & ~r_s3;
   assign w_high     = r_s2;
   assign w_at_limit = (r_cnt == TO_LIM_C);

   // Divide-ratio and duty checks on the values about to be captured.
   always_comb begin
      w_twice_h = {r_hcnt, 1'b0};
      w_per_ext = {1'b0, r_cnt};
      if (w_twice_h >= w_per_ext) begin
         w_diff = w_twice_h - w_per_ext;
      end else begin
         w_diff = w_per_ext - w_twice_h;
      end
      w_duty_ok = (w_diff <= ONE_EXT_C);
      w_div_ok  = (r_cnt == EXP_DIV_C);
   end

   // Synchronizer plus measurement state machine with registered results.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_hcnt     <= '0;
         r_low_seen <= 1'b0;
         r_period   <= '0;
         r_high_t   <= '0;
         r_valid    <= 1'b0;
         r_div_ok   <= 1'b0;
         r_duty_ok  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_s1    <= SIG_IN;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         r_valid <= 1'b0;
         if (!EN) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_low_seen <= 1'b0;
            r_timeout  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_ARM;
               end
               ST_ARM: begin
                  // First rise only starts a period; the partial one before it is discarded.
                  if (w_rise) begin
                     r_cnt      <= ONE_C;
                     r_hcnt     <= ONE_C;
                     r_low_seen <= 1'b0;
                     r_state    <= ST_MEAS;
                  end else if (w_at_limit) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                     r_hcnt    <= '0;
                  end else begin
                     r_cnt <= r_cnt + ONE_C;
                  end
               end
               ST_MEAS: begin
                  if (w_rise) begin
                     r_period   <= r_cnt;
                     r_high_t   <= r_hcnt;
                     r_div_ok   <= w_div_ok;
                     r_duty_ok  <= w_duty_ok;
                     r_valid    <= 1'b1;
                     r_timeout  <= 1'b0;
                     r_cnt      <= ONE_C;
                     r_hcnt     <= ONE_C;
                     r_low_seen <= 1'b0;
                  end else if (w_at_limit) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                     r_hcnt    <= '0;
                     r_state   <= ST_ARM;
                  end else begin
                     r_cnt <= r_cnt + ONE_C;
                     // High time stops at the first low so glitches later in the period are ignored.
                     if (w_high && !r_low_seen) begin
                        r_hcnt <= r_hcnt + ONE_C;
                     end else begin
                        r_hcnt <= r_hcnt;
                     end
                     if (!w_high) begin
                        r_low_seen <= 1'b1;
                     end else begin
                        r_low_seen <= r_low_seen;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_hcnt  <= '0;
               end
            endcase
         end
      end
   end

   assign PERIOD  = r_period;
   assign HIGH_T  = r_high_t;
   assign VALID   = r_valid;
   assign DIV_OK  = r_div_ok;
   assign DUTY_OK = r_duty_ok;
   assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_fdiv_meter.sv
// Directed bench for fdiv_meter: square-wave patterns with hand-computed period,
// high time, flag, timeout, reset and enable expectations.
module tb_fdiv_meter;

   logic       CLK = 1'b0;
   logic       RST_N, EN, SIG_IN;
   logic [7:0] PERIOD, HIGH_T;
   logic       VALID, DIV_OK, DUTY_OK, TIMEOUT;

   int vecs = 0;
   int miscomp = 0;
   int cyc_n = 0;
   int valid_cnt = 0;
   int last_valid_cyc = 0;
   int prev_valid_cyc = 0;
   int to_first_cyc = 0;
   int v0 = 0;

   fdiv_meter #(.CW(8), .EXP_DIV(5), .TO_LIMIT(255)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .SIG_IN(SIG_IN),
      .PERIOD(PERIOD), .HIGH_T(HIGH_T), .VALID(VALID),
      .DIV_OK(DIV_OK), .DUTY_OK(DUTY_OK), .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscomp++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One CLK cycle with SIG_IN = s; outputs observed 1 time unit after the edge.
   task automatic cyc(input logic s);
      SIG_IN = s;
      @(posedge CLK);
      #1;
      cyc_n++;
      if (VALID === 1'b1) begin
         valid_cnt++;
         prev_valid_cyc = last_valid_cyc;
         last_valid_cyc = cyc_n;
      end
      if (TIMEOUT === 1'b1 && to_first_cyc == 0) to_first_cyc = cyc_n;
   endtask

   task automatic wave(input int h, input int l, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < h; i++) cyc(1'b1);
         for (int i = 0; i < l; i++) cyc(1'b0);
      end
   endtask

   initial begin
      RST_N = 1'b0; EN = 1'b0; SIG_IN = 1'b0;
      #12;
      check("rst_period",  PERIOD,  0);
      check("rst_high_t",  HIGH_T,  0);
      check("rst_valid",   VALID,   0);
      check("rst_div_ok",  DIV_OK,  0);
      check("rst_duty_ok", DUTY_OK, 0);
      check("rst_timeout", TIMEOUT, 0);

      @(negedge CLK);
      RST_N = 1'b1;
      cyc(1'b0);
      EN = 1'b1;
      cyc(1'b0);

      // divide-by-5, high 3 / low 2
      v0 = valid_cnt;
      wave(3, 2, 4);
      check("div5_valid_count", valid_cnt - v0, 3);
      check("div5_valid_spacing", last_valid_cyc - prev_valid_cyc, 5);
      check("div5_period",  PERIOD,  5);
      check("div5_high_t",  HIGH_T,  3);
      check("div5_div_ok",  DIV_OK,  1);
      check("div5_duty_ok", DUTY_OK, 1);
      check("div5_timeout", TIMEOUT, 0);

      // divide-by-3, high 2 / low 1
      v0 = valid_cnt;
      wave(2, 1, 4);
      check("div3_valid_count", valid_cnt - v0, 4);
      check("div3_valid_spacing", last_valid_cyc - prev_valid_cyc, 3);
      check("div3_period",  PERIOD,  3);
      check("div3_high_t",  HIGH_T,  2);
      check("div3_div_ok",  DIV_OK,  0);
      check("div3_duty_ok", DUTY_OK, 1);

      // high 1 / low 4: right ratio, bad duty
      v0 = valid_cnt;
      wave(1, 4, 4);
      check("h1l4_valid_count", valid_cnt - v0, 4);
      check("h1l4_period",  PERIOD,  5);
      check("h1l4_high_t",  HIGH_T,  1);
      check("h1l4_div_ok",  DIV_OK,  1);
      check("h1l4_duty_ok", DUTY_OK, 0);

      // hold low: timeout 255 cycles after the last measured rise
      v0 = valid_cnt;
      to_first_cyc = 0;
      for (int i = 0; i < 300; i++) cyc(1'b0);
      check("to_latency", to_first_cyc - last_valid_cyc, 255);
      check("to_level", TIMEOUT, 1);
      check("to_no_valid", valid_cnt - v0, 0);
      check("to_period_hold", PERIOD, 5);

      // resume: first rise only arms, the next one clears TIMEOUT with VALID
      wave(3, 2, 1);
      check("resume_arm_no_valid", valid_cnt - v0, 0);
      check("resume_arm_timeout", TIMEOUT, 1);
      wave(3, 2, 1);
      check("resume_valid", valid_cnt - v0, 1);
      check("resume_timeout_clr", TIMEOUT, 0);
      check("resume_period", PERIOD, 5);
      check("resume_high_t", HIGH_T, 3);

      // asynchronous reset in the middle of a period
      cyc(1'b1);
      cyc(1'b1);
      RST_N = 1'b0;
      #1;
      check("mid_rst_period",  PERIOD,  0);
      check("mid_rst_high_t",  HIGH_T,  0);
      check("mid_rst_div_ok",  DIV_OK,  0);
      check("mid_rst_duty_ok", DUTY_OK, 0);
      check("mid_rst_valid",   VALID,   0);
      check("mid_rst_timeout", TIMEOUT, 0);
      for (int i = 0; i < 3; i++) cyc(1'b0);
      RST_N = 1'b1;
      v0 = valid_cnt;
      wave(3, 2, 1);
      check("post_rst_no_valid", valid_cnt - v0, 0);
      wave(3, 2, 1);
      check("post_rst_valid", valid_cnt - v0, 1);
      check("post_rst_period", PERIOD, 5);

      // drop EN for 4 cycles in the middle of a measurement
      cyc(1'b1);
      EN = 1'b0;
      v0 = valid_cnt;
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      check("en_off_no_valid", valid_cnt - v0, 0);
      check("en_off_valid_lvl", VALID, 0);
      check("en_off_period_hold", PERIOD, 5);
      check("en_off_timeout", TIMEOUT, 0);
      EN = 1'b1;
      cyc(1'b0);
      wave(3, 2, 1);
      check("en_rearm_no_valid", valid_cnt - v0, 0);
      wave(3, 2, 1);
      check("en_resume_valid", valid_cnt - v0, 1);
      check("en_resume_period", PERIOD, 5);
      check("en_resume_duty_ok", DUTY_OK, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
      $finish;
   end

endmodule
